// File: rtl/ifc_pkg.sv
// ifc_pkg
// Shared definitions for the BSV-style method interface blocks (ifc_or,
// ifc_fork and their benches).
//   IFC_DEFAULT_WIDTH : default data width of a method argument/return value
//   IFC_DEFAULT_DEPTH : default number of entries in a branch FIFO
//   ifc_ptr_width()   : read/write pointer width for a FIFO of a given depth
package ifc_pkg;

    localparam int IFC_DEFAULT_WIDTH = 1;
    localparam int IFC_DEFAULT_DEPTH = 2;

    // Pointers are never narrower than one bit, even for degenerate depths.
    function automatic int ifc_ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ifc_fifo.sv
// ifc_fifo
// Single-clock FIFO used as one branch buffer of ifc_fork.
// Ports:
//   CLK      : clock, rising edge
//   RST_N    : asynchronous active-low reset, empties the FIFO
//   enq_en   : write enq_data at the tail (ignored while full)
//   enq_data : word to write
//   full     : FIFO holds DEPTH entries (registered state only)
//   deq_en   : advance the head (ignored while empty)
//   deq_data : head word, 0 while empty
//   empty    : FIFO holds no entries (registered state only)
module ifc_fifo
    import ifc_pkg::*;
#(
    parameter int WIDTH = IFC_DEFAULT_WIDTH,
    parameter int DEPTH = IFC_DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             enq_en,
    input  logic [WIDTH-1:0] enq_data,
    output logic             full,
    input  logic             deq_en,
    output logic [WIDTH-1:0] deq_data,
    output logic             empty
);

    localparam int          PW        = ifc_ptr_width(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q,  count_d;
    logic             do_enq;
    logic             do_deq;

    // Full/empty come from the occupancy count so that equal pointers are
    // never ambiguous.
    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign do_enq   = enq_en && !full;
    assign do_deq   = deq_en && !empty;
    assign deq_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_enq) begin
            mem_d[wr_ptr_q] = enq_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifc_fork.sv
// ifc_fork
// Copies every word accepted on action method x into two independent
// actionvalue outputs p and q, each buffered by its own FIFO.
// Ports:
//   CLK, RST_N     : clock (rising edge), asynchronous active-low reset
//   x_data/x_en    : action method x argument and enable
//   x_rdy          : x may fire (neither branch full, out of reset)
//   p_en/q_en      : dequeue enables of the two branches
//   p_data/q_data  : branch heads, 0 while empty
//   p_rdy/q_rdy    : branch non-empty
//   err            : sticky flag, set by any enable asserted while not ready
module ifc_fork
    import ifc_pkg::*;
#(
    parameter int WIDTH = IFC_DEFAULT_WIDTH,
    parameter int DEPTH = IFC_DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] x_data,
    input  logic             x_en,
    output logic             x_rdy,
    input  logic             p_en,
    output logic [WIDTH-1:0] p_data,
    output logic             p_rdy,
    input  logic             q_en,
    output logic [WIDTH-1:0] q_data,
    output logic             q_rdy,
    output logic             err
);

    logic full_p, full_q;
    logic empty_p, empty_q;
    logic x_fire, p_fire, q_fire;
    logic violation;
    logic live_q, live_d;
    logic err_q, err_d;

    // live_q holds x_rdy low during reset and rises on the first edge after
    // release, so x_rdy depends on registered state only.
    assign x_rdy = live_q && !full_p && !full_q;
    assign p_rdy = !empty_p;
    assign q_rdy = !empty_q;
    assign err   = err_q;

    // Enables without the matching ready are dropped here so a bad enable on
    // one method can never disturb either FIFO.
    assign x_fire    = x_en && x_rdy;
    assign p_fire    = p_en && p_rdy;
    assign q_fire    = q_en && q_rdy;
    assign violation = (x_en && !x_rdy) || (p_en && !p_rdy) || (q_en && !q_rdy);

    always_comb begin
        live_d = 1'b1;
        err_d  = err_q || violation;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            live_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            live_q <= live_d;
            err_q  <= err_d;
        end
    end

    ifc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_p (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .enq_en   (x_fire),
        .enq_data (x_data),
        .full     (full_p),
        .deq_en   (p_fire),
        .deq_data (p_data),
        .empty    (empty_p)
    );

    ifc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_q (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .enq_en   (x_fire),
        .enq_data (x_data),
        .full     (full_q),
        .deq_en   (q_fire),
        .deq_data (q_data),
        .empty    (empty_q)
    );

endmodule

// File: tb/tb_ifc_fork.sv
// tb_ifc_fork
// Self-checking bench for ifc_fork. A queue per branch holds the words the
// bench expects to see; readiness, heads and the err flag are compared with
// that model after every clock.
module tb_ifc_fork;

    localparam int WIDTH = 1;
    localparam int DEPTH = 2;

    logic             CLK    = 1'b0;
    logic             RST_N  = 1'b0;
    logic [WIDTH-1:0] x_data = '0;
    logic             x_en   = 1'b0;
    logic             p_en   = 1'b0;
    logic             q_en   = 1'b0;
    logic             x_rdy;
    logic [WIDTH-1:0] p_data;
    logic             p_rdy;
    logic [WIDTH-1:0] q_data;
    logic             q_rdy;
    logic             err;

    int               checkCount = 0;
    int               passCount  = 0;
    logic [WIDTH-1:0] expP[$];
    logic [WIDTH-1:0] expQ[$];
    logic             modelLive = 1'b0;
    logic             errExp    = 1'b0;

    ifc_fork #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .x_data (x_data),
        .x_en   (x_en),
        .x_rdy  (x_rdy),
        .p_en   (p_en),
        .p_data (p_data),
        .p_rdy  (p_rdy),
        .q_en   (q_en),
        .q_data (q_data),
        .q_rdy  (q_rdy),
        .err    (err)
    );

    always #5 CLK = ~CLK;

    // x may fire only when live and neither branch holds DEPTH words.
    function automatic logic modelXrdy();
        return modelLive && (expP.size() < DEPTH) && (expQ.size() < DEPTH);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag);
        logic [WIDTH-1:0] headP;
        logic [WIDTH-1:0] headQ;
        headP = (expP.size() > 0) ? expP[0] : '0;
        headQ = (expQ.size() > 0) ? expQ[0] : '0;
        checkOutput({tag, "/x_rdy"},  32'(x_rdy),  32'(modelXrdy()));
        checkOutput({tag, "/p_rdy"},  32'(p_rdy),  32'(expP.size() > 0));
        checkOutput({tag, "/q_rdy"},  32'(q_rdy),  32'(expQ.size() > 0));
        checkOutput({tag, "/p_data"}, 32'(p_data), 32'(headP));
        checkOutput({tag, "/q_data"}, 32'(q_data), 32'(headQ));
        checkOutput({tag, "/err"},    32'(err),    32'(errExp));
    endtask

    // Drive one cycle of method enables, update the model with what should
    // fire on the coming edge, then check the state just after that edge.
    task automatic applyStimulus(input string tag, input logic xe,
                                 input logic [WIDTH-1:0] xd,
                                 input logic pe, input logic qe);
        logic fx, fp, fq;
        x_en   = xe;
        x_data = xd;
        p_en   = pe;
        q_en   = qe;
        fx = xe && modelXrdy();
        fp = pe && (expP.size() > 0);
        fq = qe && (expQ.size() > 0);
        if ((xe && !fx) || (pe && !fp) || (qe && !fq)) errExp = 1'b1;
        @(posedge CLK);
        #1;
        if (fp) void'(expP.pop_front());
        if (fq) void'(expQ.pop_front());
        if (fx) begin
            expP.push_back(xd);
            expQ.push_back(xd);
        end
        modelLive = 1'b1;
        x_en = 1'b0;
        p_en = 1'b0;
        q_en = 1'b0;
        checkState(tag);
    endtask

    task automatic clearModel();
        expP.delete();
        expQ.delete();
        modelLive = 1'b0;
        errExp    = 1'b0;
    endtask

    task automatic holdReset(input int cycles);
        RST_N = 1'b0;
        clearModel();
        #1;
        checkState("reset_assert");
        repeat (cycles) @(posedge CLK);
        #1;
        checkState("reset_hold");
        RST_N = 1'b1;
        #1;
        checkState("reset_release");
    endtask

    initial begin
        int sent;
        logic xe, pe, qe;
        logic [WIDTH-1:0] xd;

        // Reset and first edge after release
        holdReset(3);
        applyStimulus("first_edge", 1'b0, '0, 1'b0, 1'b0);

        // Basic fork, then independent drains
        applyStimulus("fork_x", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("fork_p", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("fork_q", 1'b0, 1'b0, 1'b0, 1'b1);

        // Fill to DEPTH, drain Q only (P stays full), then one p frees x
        applyStimulus("fill_1",  1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("fill_0",  1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("drain_q1", 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("drain_q0", 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("drain_p1", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("drain_p0", 1'b0, 1'b0, 1'b1, 1'b0);

        // Streaming 1,0,1,0... with simultaneous enqueue and dequeue
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            xe = (sent < 8) && modelXrdy();
            xd = WIDTH'((sent + 1) % 2);
            pe = (expP.size() > 0);
            qe = (expQ.size() > 0);
            if (xe) sent++;
            applyStimulus("stream", xe, xd, pe, qe);
        end

        // Violations: dequeue from empty, then enqueue into full
        applyStimulus("viol_p",  1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("vfill_1", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("vfill_0", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("viol_x",  1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("vdrain_p", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("vdrain_q", 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("err_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges with words buffered
        RST_N = 1'b0;
        clearModel();
        #1;
        checkState("async_reset");
        #2;
        RST_N = 1'b1;
        #1;
        checkState("async_release");
        applyStimulus("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("post_x",     1'b1, 1'b1, 1'b0, 1'b0);

        // Random legal traffic with independent consumer rates
        for (int c = 0; c < 40; c++) begin
            xe = 1'(($urandom_range(0, 3) != 0)) && modelXrdy();
            xd = WIDTH'($urandom);
            pe = 1'($urandom_range(0, 1)) && (expP.size() > 0);
            qe = 1'($urandom_range(0, 2) == 0) && (expQ.size() > 0);
            applyStimulus("random", xe, xd, pe, qe);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ifc_fork.md
Name: ifc_fork

Overview:
- Fan-out block at the other end of the BSV-style method interface used by ifc_or.
- ifc_or merges two action-method inputs into one actionvalue output. ifc_fork does the reverse: it accepts one action-method input x and copies every word into two independent actionvalue outputs p and q.
- Each branch is buffered by its own FIFO, so p and q consumers drain at their own rates.
- Sits upstream of a pair of consumers, or feeds ifc_or's a/b methods in loopback benches.

Parameters:
- WIDTH, 1, data width of x/p/q (1 matches ifc_or).
- DEPTH, 2, entries per branch FIFO; power of two, >= 2.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- x_data  input  WIDTH  action method x argument.
- x_en  input  1  action method x enable.
- x_rdy  output  1  action method x ready.
- p_en  input  1  actionvalue method p enable (dequeue).
- p_data  output  WIDTH  method p return value (head of FIFO P).
- p_rdy  output  1  method p ready (FIFO P non-empty).
- q_en  input  1  actionvalue method q enable (dequeue).
- q_data  output  WIDTH  method q return value (head of FIFO Q).
- q_rdy  output  1  method q ready (FIFO Q non-empty).
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset:
  - One clock, CLK. RST_N is asynchronous, active-low: assertion clears state immediately; deassertion is sampled on CLK.
  - While RST_N=0: both FIFOs empty, pointers and counts 0, x_rdy=0, p_rdy=0, q_rdy=0, p_data=0, q_data=0, err=0.
  - First rising edge with RST_N=1: x_rdy=1.
- Method semantics:
  - Enable is legal only while the matching rdy=1; the method fires on the rising edge.
  - x_rdy = !fullP && !fullQ, computed from registered state only. There is no combinational path from p_en/q_en to x_rdy.
  - p_rdy = !emptyP and q_rdy = !emptyQ, both registered-state only.
  - p_data/q_data show the FIFO head combinationally while rdy=1, and read 0 when empty.
- x fire: x_data is written to the tail of both FIFOs on the same edge. Branches never diverge in content, only in occupancy.
- Latency: x fire at edge N gives p_rdy/q_rdy=1 after edge N, with data equal to x_data. There is no same-cycle bypass.
- Ordering: each branch is strict FIFO and returns words in x order.
- Simultaneous x fire and p fire:
  - Legal only when x_rdy=1.
  - Count of P is unchanged; the head advances and the tail is written.
  - A full P blocks x even if p_en=1 that cycle (x_rdy was already 0).
- Full: when either FIFO holds DEPTH entries, x_rdy=0. A single p or q dequeue restores x_rdy on the next cycle, provided the other FIFO is not full.
- Empty: p_en with p_rdy=0 is a violation. Same for q.
- Pointer wrap: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Full/empty are decided from a (log2(DEPTH)+1)-bit occupancy count, not from pointer equality.
- Protocol violations (x_en && !x_rdy, p_en && !p_rdy, q_en && !q_rdy):
  - The enable is ignored: no state change, no data dropped from the other branch.
  - err is set on the next edge and stays 1 until reset.
- Reset mid-operation: all buffered words are discarded and every output returns to its reset value asynchronously. No partial word survives.

Decomposition:
- Shared package ifc_pkg:
  - IFC_DEFAULT_WIDTH=1 and IFC_DEFAULT_DEPTH=2.
  - A clog2-based pointer-width constant function.
  - Used by ifc_or benches and ifc_fork.
- One sub-module, ifc_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports CLK, RST_N, enq_en, enq_data, full, deq_en, deq_data, empty.
  - Async active-low reset.
  - Instantiated twice (P and Q).
- Top level holds the x_rdy AND, the violation detection and the err register.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with x_en=0 -> x_rdy=0, p_rdy=0, q_rdy=0, err=0. On release, x_rdy=1 after the first edge.
- Basic fork: fire x with data 1 -> next cycle p_rdy=1, q_rdy=1, p_data=1, q_data=1. Fire p only -> p_rdy=0, q_rdy=1, q_data=1.
- Fill and backpressure (DEPTH=2): fire x=1, then x=0, with no dequeues -> x_rdy=0. Fire q twice -> q_data 1 then 0, x_rdy stays 0 (P full). One p fire -> x_rdy=1 next cycle.
- Streaming with simultaneous enq/deq: 8 x fires with alternating data 1,0,1,0..., p_en/q_en held 1 whenever rdy -> 8 words on each branch in order, err=0, counts never exceed DEPTH.
- Violation: drive p_en=1 while p_rdy=0, then x_en=1 while x_rdy=0 -> FIFO contents unchanged, err=1 from the next edge and held until RST_N=0.
- Reset mid-operation: with one word in each FIFO, pulse RST_N=0 between edges -> p_rdy=0, q_rdy=0, x_rdy=0 immediately. After release both FIFOs are empty and x_rdy=1.
